// File: rtl/pipeline_mem_stage_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes and
// the request/acknowledge sequencer states.
package pipeline_mem_stage_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_FULL = 2'b11
  } memSizeE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } memStateE;

endpackage

// File: rtl/pipeline_mem_stage_lane_format.sv
// Big-endian byte-lane formatting: byte enables, store data replication and
// load data extraction with sign/zero extension. Lane 0 is the MSB byte.
module mem_lane_format
  import pipeline_mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NBYTES = DATA_W / 8,
  localparam int LANE_W = $clog2(NBYTES)
) (
  input  logic [LANE_W-1:0] addrLow,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [DATA_W-1:0] storeData,
  input  logic [DATA_W-1:0] readData,
  output logic [NBYTES-1:0] byteEn,
  output logic [DATA_W-1:0] laneData,
  output logic [DATA_W-1:0] loadData
);

  localparam int SH_W = LANE_W + 4;

  logic [LANE_W:0]   numBytes;
  logic [LANE_W:0]   endLane;
  logic [SH_W-1:0]   shAmt;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic              signBit;

  always_comb begin
    numBytes = '0;
    laneData = '0;
    mask     = '0;
    case (memSizeE'(size))
      SZ_BYTE: begin
        numBytes = (LANE_W+1)'(1);
        laneData = {NBYTES{storeData[7:0]}};
        mask     = DATA_W'(8'hFF);
      end
      SZ_HALF: begin
        numBytes = (LANE_W+1)'(2);
        laneData = {(NBYTES/2){storeData[15:0]}};
        mask     = DATA_W'(16'hFFFF);
      end
      SZ_WORD: begin
        numBytes = (LANE_W+1)'(4);
        laneData = {(NBYTES/4){storeData[31:0]}};
        mask     = DATA_W'(32'hFFFF_FFFF);
      end
      default: begin
        numBytes = (LANE_W+1)'(NBYTES);
        laneData = storeData;
        mask     = '1;
      end
    endcase
  end

  // The accessed lanes end at byte endLane; shifting by the bytes below it
  // right-aligns the field.
  assign endLane = {1'b0, addrLow} + numBytes;
  assign shAmt   = SH_W'(DATA_W) - {endLane, 3'b000};
  assign shifted = readData >> shAmt;

  always_comb begin
    byteEn = '0;
    for (int i = 0; i < NBYTES; i++) begin
      byteEn[i] = ((LANE_W+1)'(NBYTES-1-i) >= {1'b0, addrLow}) &&
                  ((LANE_W+1)'(NBYTES-1-i) < endLane);
    end
  end

  always_comb begin
    signBit = 1'b0;
    case (memSizeE'(size))
      SZ_BYTE: signBit = sign & shifted[7];
      SZ_HALF: signBit = sign & shifted[15];
      SZ_WORD: signBit = sign & shifted[31];
      default: signBit = 1'b0;
    endcase
    loadData = (shifted & mask) | (signBit ? ~mask : '0);
  end

endmodule

// File: rtl/pipeline_mem_stage.sv
// MEM-stage load/store unit with a request/acknowledge memory port,
// wait-state tolerant stalling, misalignment detection and bus timeout.
module pipeline_mem_stage
  import pipeline_mem_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 15,
  localparam int NBYTES     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_rd,
  input  logic              in_wr,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [1:0]        in_size,
  input  logic              in_sign,
  input  logic [4:0]        in_rw,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [NBYTES-1:0] mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_rw,
  output logic              misalign_exc,
  output logic              bus_err
);

  localparam int LANE_W = $clog2(NBYTES);
  localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);

  memStateE          state, nextState;
  logic [ADDR_W-1:0] addrQ;
  logic [1:0]        sizeQ;
  logic              signQ;
  logic [DATA_W-1:0] wdataQ;
  logic [4:0]        rwQ;
  logic              weQ;
  logic [CNT_W-1:0]  cnt;

  logic              outValidQ;
  logic [DATA_W-1:0] outDataQ;
  logic [4:0]        outRwQ;
  logic              misQ;
  logic              busErrQ;

  logic              memOp;
  logic              misaligned;
  logic              timeoutHit;
  logic              stallComb;
  logic              busy;
  logic [NBYTES-1:0] fmtBe;
  logic [DATA_W-1:0] fmtWdata;
  logic [DATA_W-1:0] fmtLoad;

  assign memOp      = in_valid & (in_rd | in_wr);
  assign timeoutHit = (cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign busy       = (state == ST_BUSY);

  always_comb begin
    misaligned = 1'b0;
    case (memSizeE'(in_size))
      SZ_HALF: misaligned = in_addr[0];
      SZ_WORD: misaligned = |in_addr[1:0];
      SZ_FULL: misaligned = |in_addr[LANE_W-1:0];
      default: misaligned = 1'b0;
    endcase
  end

  mem_lane_format #(
    .DATA_W(DATA_W)
  ) uFormat (
    .addrLow  (addrQ[LANE_W-1:0]),
    .size     (sizeQ),
    .sign     (signQ),
    .storeData(wdataQ),
    .readData (mem_rdata),
    .byteEn   (fmtBe),
    .laneData (fmtWdata),
    .loadData (fmtLoad)
  );

  always_comb begin
    nextState = state;
    stallComb = 1'b0;
    case (state)
      ST_IDLE: begin
        if (memOp && !misaligned) begin
          stallComb = 1'b1;
          nextState = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stallComb = 1'b1;
        if (mem_ack || timeoutHit) begin
          nextState = ST_DONE;
        end
      end
      ST_DONE: nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  // Result registers are one-cycle pulses except out_data/out_rw, which hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      addrQ     <= '0;
      sizeQ     <= '0;
      signQ     <= 1'b0;
      wdataQ    <= '0;
      rwQ       <= '0;
      weQ       <= 1'b0;
      cnt       <= '0;
      outValidQ <= 1'b0;
      outDataQ  <= '0;
      outRwQ    <= '0;
      misQ      <= 1'b0;
      busErrQ   <= 1'b0;
    end else begin
      state     <= nextState;
      outValidQ <= 1'b0;
      misQ      <= 1'b0;
      busErrQ   <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (memOp && !misaligned) begin
            addrQ  <= in_addr;
            sizeQ  <= in_size;
            signQ  <= in_sign;
            wdataQ <= in_wdata;
            rwQ    <= in_rw;
            weQ    <= in_wr;
          end else if (memOp) begin
            misQ <= 1'b1;
          end else if (in_valid) begin
            outValidQ <= 1'b1;
            outDataQ  <= DATA_W'(in_addr);
            outRwQ    <= in_rw;
          end
        end
        ST_BUSY: begin
          if (mem_ack) begin
            outValidQ <= 1'b1;
            outDataQ  <= weQ ? '0 : fmtLoad;
            outRwQ    <= rwQ;
            cnt       <= '0;
          end else if (timeoutHit) begin
            busErrQ  <= 1'b1;
            outDataQ <= '0;
            outRwQ   <= rwQ;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Stall is masked by reset so an in-flight access is released immediately.
  assign stall        = stallComb & ~reset;
  assign mem_req      = busy;
  assign mem_we       = busy & weQ;
  assign mem_addr     = busy ? {addrQ[ADDR_W-1:LANE_W], {LANE_W{1'b0}}} : '0;
  assign mem_be       = busy ? fmtBe : '0;
  assign mem_wdata    = busy ? fmtWdata : '0;
  assign out_valid    = outValidQ;
  assign out_data     = outDataQ;
  assign out_rw       = outRwQ;
  assign misalign_exc = misQ;
  assign bus_err      = busErrQ;

endmodule
